// File: rtl/tx_uart.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tx_uart                                                      |
// | Description : UART transmitter, LSB first, 16x oversampled bit timing.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tx_uart #(
  parameter int NB_BITS = 8,
  parameter int SB_TICK = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rate,
  input  logic               i_tx_start,
  input  logic [NB_BITS-1:0] i_data,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic               o_busy
);

  // Tick counter is 4 bits unless a stop bit longer than 16 ticks needs more.
  localparam int c_tick_w = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int c_bit_w  = (NB_BITS > 1) ? $clog2(NB_BITS) : 1;

  localparam logic [c_tick_w-1:0] c_tick_bit  = c_tick_w'(15);
  localparam logic [c_tick_w-1:0] c_tick_stop = c_tick_w'(SB_TICK - 1);
  localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(NB_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_tick_w-1:0]  r_tick;
  logic [c_tick_w-1:0]  w_tick_nxt;
  logic [c_bit_w-1:0]   r_bit;
  logic [c_bit_w-1:0]   w_bit_nxt;
  logic [NB_BITS-1:0]   r_shreg;
  logic [NB_BITS-1:0]   w_shreg_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 w_done;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // The line level is computed for the next state so it changes on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    w_tx_nxt    = r_tx;
    w_done      = 1'b0;

    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (i_tx_start) begin
          w_shreg_nxt = i_data;
          w_tick_nxt  = '0;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
        end
      end

      START: begin
        if (i_rate) begin
          if (r_tick == c_tick_bit) begin
            w_tick_nxt  = '0;
            w_bit_nxt   = '0;
            w_state_nxt = DATA;
            w_tx_nxt    = r_shreg[0];
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
      end

      DATA: begin
        if (i_rate) begin
          if (r_tick == c_tick_bit) begin
            w_tick_nxt  = '0;
            w_shreg_nxt = r_shreg >> 1;
            if (r_bit == c_bit_last) begin
              w_state_nxt = STOP;
              w_tx_nxt    = 1'b1;
            end else begin
              w_bit_nxt = r_bit + 1'b1;
              w_tx_nxt  = w_shreg_nxt[0];
            end
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
      end

      STOP: begin
        w_tx_nxt = 1'b1;
        if (i_rate) begin
          if (r_tick == c_tick_stop) begin
            w_tick_nxt  = '0;
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  assign o_tx      = r_tx;
  assign o_tx_done = w_done;
  assign o_busy    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tx_uart.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tx_uart                                                   |
// | Description : Scoreboard bench for tx_uart; a line monitor decodes frames. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tx_uart;

  typedef struct {
    logic [7:0] data;
    int         len;
    bit         btb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rate0;
  logic       rate32;
  logic       start0;
  logic       start32;
  logic [7:0] data;
  logic       tx0, done0, busy0;
  logic       tx32, done32, busy32;
  logic       m_tx, m_done, m_busy;
  bit         sel = 1'b0;

  exp_t       exp_q[$];
  exp_t       cur;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  bit         in_frame = 1'b0;
  bit         frm_ok;
  int         k;
  int         gap = 0;
  int         p;
  int         sb;
  logic [7:0] sh;
  int         ph = 0;

  always #5 clk = ~clk;

  tx_uart #(.NB_BITS(8), .SB_TICK(16)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_rate(rate0), .i_tx_start(start0),
    .i_data(data), .o_tx(tx0), .o_tx_done(done0), .o_busy(busy0)
  );

  tx_uart #(.NB_BITS(8), .SB_TICK(32)) dut32 (
    .i_clk(clk), .i_rst(rst_n), .i_rate(rate32), .i_tx_start(start32),
    .i_data(data), .o_tx(tx32), .o_tx_done(done32), .o_busy(busy32)
  );

  assign m_tx   = sel ? tx32   : tx0;
  assign m_done = sel ? done32 : done0;
  assign m_busy = sel ? busy32 : busy0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One tick every 4 clocks for the SB_TICK=32 instance.
  initial begin
    rate32 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph     = (ph + 1) % 4;
      rate32 = (ph == 0);
    end
  end

  // Line monitor: samples each bit centre, pops the expectation on frame start.
  initial begin
    forever begin
      @(negedge clk);
      p  = sel ? 4 : 1;
      sb = sel ? 32 : 16;
      if (rst_n !== 1'b1) begin
        in_frame = 1'b0;
        gap      = 0;
      end else if (!in_frame) begin
        if (m_done === 1'b1) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end
        if (m_tx === 1'b0) begin
          in_frame = 1'b1;
          k        = 1;
          sh       = '0;
          frm_ok   = (m_busy === 1'b1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_frame: got frame expected none");
            cur = '{data: 8'h00, len: 0, btb: 1'b0};
          end else begin
            cur = exp_q.pop_front();
            if (cur.btb) check("b2b_gap_le1", 32'(gap <= 1), 32'd1);
          end
        end else begin
          gap++;
        end
      end else begin
        k++;
        if (m_busy !== 1'b1) frm_ok = 1'b0;
        if (k == 8 * p && m_tx !== 1'b0) frm_ok = 1'b0;
        for (int j = 1; j <= 8; j++)
          if (k == (16 * j + 8) * p) sh[j-1] = m_tx;
        if (k == (144 + sb / 2) * p && m_tx !== 1'b1) frm_ok = 1'b0;
        if (m_done === 1'b1) begin
          check("rx_data", 32'(sh), 32'(cur.data));
          check("frame_len", k, cur.len);
          check("framing_busy", 32'(frm_ok), 32'd1);
          done_cnt++;
          in_frame = 1'b0;
          gap      = 0;
        end else if (k > cur.len + 20) begin
          n_cmp++;
          n_fail++;
          $display("FAIL frame_timeout: got %0d cycles expected %0d", k, cur.len);
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic send0(input logic [7:0] d);
    exp_q.push_back('{data: d, len: 160, btb: 1'b0});
    data   = d;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    data   = d ^ 8'h6b;
  endtask

  task automatic wait_done(input int target, input int budget);
    int t = 0;
    while (done_cnt < target && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("done_count", done_cnt, target);
  endtask

  initial begin
    rst_n   = 1'b1;
    rate0   = 1'b1;
    start0  = 1'b0;
    start32 = 1'b0;
    data    = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_tx", tx0, 1);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_tx32", tx32, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_tx", tx0, 1);
    check("idle_busy", busy0, 0);

    // Basic frames, rate tied high.
    send0(8'h51); wait_done(1, 400);
    send0(8'h00); wait_done(2, 400);
    send0(8'hFF); wait_done(3, 400);
    send0(8'hA5); wait_done(4, 400);

    // Start pulse mid-frame must be ignored.
    send0(8'hC3);
    repeat (50) @(posedge clk);
    #1;
    data   = 8'h3C;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    wait_done(5, 400);
    repeat (200) @(posedge clk);
    #1;
    check("no_extra_frame", done_cnt, 5);
    check("idle_after_c3", busy0, 0);

    // Held start: three back-to-back frames.
    exp_q.push_back('{data: 8'h55, len: 160, btb: 1'b0});
    exp_q.push_back('{data: 8'h55, len: 160, btb: 1'b1});
    exp_q.push_back('{data: 8'h55, len: 160, btb: 1'b1});
    data   = 8'h55;
    start0 = 1'b1;
    wait_done(8, 1000);
    start0 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("b2b_stopped", busy0, 0);

    // Reset in the middle of data bit 3 aborts the frame silently.
    send0(8'hF0);
    repeat (70) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_tx", tx0, 1);
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 8);
    send0(8'h81); wait_done(9, 400);

    // SB_TICK=32 instance, tick every 4 clocks, start aligned to a tick.
    sel = 1'b1;
    repeat (5) @(posedge clk);
    do begin
      @(posedge clk);
      #2;
    end while (rate32 !== 1'b1);
    exp_q.push_back('{data: 8'h5A, len: 704, btb: 1'b0});
    data    = 8'h5A;
    start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    data    = 8'h00;
    wait_done(10, 1000);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/tx_uart.md
TX_UART -- requirements
Module: tx_uart

Interface
REQ-001 Parameter NB_BITS, default 8: number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16: stop-bit length in i_rate ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 i_clk  input  1: single clock; all logic on rising edge.
REQ-004 i_rst  input  1: asynchronous reset, active-low.
REQ-005 i_rate  input  1: one-cycle oversampling tick at 16x baud, from the same baud-rate generator that drives the receiver.
REQ-006 i_tx_start  input  1: request to send a frame; sampled only in IDLE.
REQ-007 i_data  input  NB_BITS: byte to transmit; captured on the cycle the start is accepted.
REQ-008 o_tx  output  1: serial line, idle-high, registered.
REQ-009 o_tx_done  output  1: one-cycle pulse at end of stop bit.
REQ-010 o_busy  output  1: high in every state except IDLE.

Function
REQ-011 The FSM SHALL have four states: IDLE, START, DATA, STOP, with a 4-bit tick counter, a bit counter of width ceil(log2(NB_BITS)), and an NB_BITS shift register.
REQ-012 IDLE: o_tx=1; if i_tx_start=1 then load the shift register from i_data, clear the tick counter, and go to START; i_rate is ignored in IDLE.
REQ-013 START: o_tx=0; on each i_rate the tick counter increments; on the i_rate where tick=15, clear tick and bit counters and go to DATA.
REQ-014 DATA: o_tx = shift register bit 0 (LSB first); on the i_rate where tick=15, shift right by one, clear tick, and increment the bit counter; after bit NB_BITS-1 go to STOP.
REQ-015 STOP: o_tx=1; on the i_rate where tick=SB_TICK-1, pulse o_tx_done for exactly one cycle and return to IDLE.
REQ-016 o_tx SHALL be a registered output updated on the same edge as the state change, so the falling start edge appears on the clock edge that accepts i_tx_start.
REQ-017 Each start and data bit SHALL last exactly 16 i_rate ticks; the stop bit SHALL last SB_TICK ticks; a frame SHALL last (16*(NB_BITS+1)+SB_TICK) ticks.
REQ-018 Cycles without i_rate SHALL hold all counters and o_tx.
REQ-019 i_tx_start while o_busy=1 SHALL be ignored, with no queuing; i_data changes after acceptance SHALL NOT affect the frame in flight.
REQ-020 i_tx_start asserted in the cycle o_tx_done pulses SHALL be ignored (state is STOP); a start held high SHALL be accepted on the next cycle, giving back-to-back frames with zero idle-bit gap.
REQ-021 o_tx_done SHALL NOT assert for a frame aborted by reset.
REQ-022 The tick counter SHALL never exceed 15 in START/DATA nor SB_TICK-1 in STOP; no wrap-around states SHALL be reachable.

Reset
REQ-023 While i_rst=0, asynchronously: state=IDLE, o_tx=1, o_tx_done=0, o_busy=0, and all counters and the shift register cleared.
REQ-024 Reset asserted mid-frame SHALL drive o_tx high immediately, without waiting for a clock edge; the partial frame is abandoned.
REQ-025 After reset deassertion the first accepted i_tx_start SHALL begin a clean frame.

Verification
REQ-026 i_rate tied high, send i_data=0x51 -> o_tx: 16 cycles of 0, then 1,0,0,0,1,0,1,0 at 16 cycles each, then 16 cycles of 1; o_tx_done pulses at cycle 160 after accept; o_busy high for 160 cycles.
REQ-027 Loopback with Baud_rate_gen driving tx_uart -> Rx_uart: bytes 0x00, 0xFF, 0xA5, 0x51 are received with Rx_uart o_data equal to each byte and one o_rx_done per frame.
REQ-028 i_tx_start pulsed with 0x3C mid-frame while sending 0xC3 -> only 0xC3 is transmitted, frame length unchanged, a single o_tx_done.
REQ-029 i_tx_start held high, i_data=0x55 -> back-to-back frames; the start bit follows the stop bit with 1 clock of idle at most; o_tx_done once per frame.
REQ-030 i_rst pulled low during DATA bit 3 -> o_tx=1 and o_busy=0 within the same cycle, no o_tx_done; the next frame 0x81 is received correctly by Rx_uart.
REQ-031 SB_TICK=32 with i_rate every 4 clocks -> the stop bit lasts 128 clocks and the frame lasts 4*(144+32)=704 clocks.
